axi_err_responder: RTL and testbench

Terminating AXI4 subordinate that completes every transaction it receives with an error response. It sits on the manager side of the AXI monitor: when the monitor isolates a hung subordinate, it steers the manager port here so that outstanding and new requests complete cleanly instead of stalling the system. Write and read channels are served by two independent FSMs, each with one transaction outstanding.

---
 rtl/axi_err_responder_pkg.sv | 105 ++++++++++
 rtl/axi_err_responder_if.sv | 12 +
 rtl/axi_err_resp_rd.sv | 77 +++++++
 rtl/axi_err_responder.sv | 155 +++++++++++++++
 tb/tb_axi_err_responder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_err_responder_pkg.sv
// Shared AXI types and constants for the error responder and the monitor's
// manager side: channel payload structs, request/response bundles, FSM
// state enums, response codes and the default R payload.
package axi_err_responder_pkg;

    localparam int unsigned AxiIdWidth   = 6;
    localparam int unsigned AxiAddrWidth = 32;
    localparam int unsigned AxiDataWidth = 64;
    localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;
    localparam int unsigned AxiUserWidth = 1;
    localparam int unsigned AxiLenWidth  = 8;
    localparam int unsigned AxiAtopWidth = 6;
    localparam int unsigned CntWidth     = 16;

    // atop[5] set means the atomic also returns read data
    localparam int unsigned AtopRRespBit = 5;

    typedef logic [AxiIdWidth-1:0]   id_t;
    typedef logic [AxiAddrWidth-1:0] addr_t;
    typedef logic [AxiDataWidth-1:0] data_t;
    typedef logic [AxiStrbWidth-1:0] strb_t;
    typedef logic [AxiUserWidth-1:0] user_t;
    typedef logic [AxiLenWidth-1:0]  len_t;
    typedef logic [AxiAtopWidth-1:0] atop_t;
    typedef logic [1:0]              resp_code_t;
    typedef logic [CntWidth-1:0]     cnt_t;

    localparam resp_code_t  RESP_SLVERR   = 2'b10;
    localparam resp_code_t  RESP_DECERR   = 2'b11;
    localparam logic [63:0] RDATA_DEFAULT = 64'hBADC_AB1E_DEAD_BEEF;
    localparam cnt_t        CNT_MAX       = {CntWidth{1'b1}};

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        logic [2:0] size;
        logic [1:0] burst;
        atop_t      atop;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        resp_code_t resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        resp_code_t resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } mst_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } mst_resp_t;

    typedef mst_req_t  req_t;
    typedef mst_resp_t resp_t;

endpackage

// File: rtl/axi_err_responder_if.sv
// Manager-side AXI bundle between the monitor and the error responder.
//   req  : request struct driven by the manager
//   resp : response struct driven by the subordinate
interface axi_err_responder_if;
    import axi_err_responder_pkg::*;

    mst_req_t  req;
    mst_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/axi_err_resp_rd.sv
// Read-side FSM of the error responder: accepts one AR (or a load from the
// write side for atomics) and returns len+1 error beats.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   ar_en_i         : permission to accept an AR this cycle
//   ar_valid_i/id/len : AR request
//   load_i/id/len   : inject a burst from an atomic AW (takes priority)
//   r_ready_i       : R handshake from the manager
//   ar_ready_o, r_valid_o, r_id_o, r_last_o : channel outputs
//   idle_o          : FSM is in R_IDLE
module axi_err_resp_rd
    import axi_err_responder_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic ar_en_i,
    input  logic ar_valid_i,
    input  id_t  ar_id_i,
    input  len_t ar_len_i,
    input  logic load_i,
    input  id_t  load_id_i,
    input  len_t load_len_i,
    input  logic r_ready_i,
    output logic ar_ready_o,
    output logic r_valid_o,
    output id_t  r_id_o,
    output logic r_last_o,
    output logic idle_o
);

    r_state_e state_q;
    id_t      id_q;
    len_t     len_q;
    len_t     cnt_q;

    assign idle_o     = (state_q == R_IDLE);
    assign ar_ready_o = idle_o && ar_en_i;
    assign r_valid_o  = (state_q == R_DATA);
    assign r_id_o     = id_q;
    // 8-bit counter vs 8-bit len: len=255 ends exactly on the 256th beat
    assign r_last_o   = (state_q == R_DATA) && (cnt_q == len_q);

    // Read FSM and beat counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (load_i) begin
                        id_q    <= load_id_i;
                        len_q   <= load_len_i;
                        cnt_q   <= '0;
                        state_q <= R_DATA;
                    end else if (ar_valid_i && ar_ready_o) begin
                        id_q    <= ar_id_i;
                        len_q   <= ar_len_i;
                        cnt_q   <= '0;
                        state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready_i) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == len_q) begin
                            state_q <= R_IDLE;
                        end
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_err_responder.sv
// Terminating AXI4 subordinate: completes every write and read with an
// error response. Independent write and read FSMs, one transaction each.
// Optional completion counters are built when AXI_ERR_RESP_CNT_EN is defined;
// otherwise wr_cnt_o/rd_cnt_o are tied to 0.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : gate for new AW/AR; running transactions always finish
//   axi          : manager-side AXI bundle (slave modport)
//   busy_o       : either FSM not idle
//   wr_cnt_o     : completed B handshakes (saturating)
//   rd_cnt_o     : completed last-beat R handshakes (saturating)
module axi_err_responder
    import axi_err_responder_pkg::*;
#(
    parameter resp_code_t  RespCode = RESP_SLVERR,
    parameter logic [63:0] RData    = RDATA_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    axi_err_responder_if.slave   axi,
    output logic                 busy_o,
    output cnt_t                 wr_cnt_o,
    output cnt_t                 rd_cnt_o
);

    w_state_e w_state_q;
    id_t      b_id_q;
    logic     live_q;

    logic aw_is_atop;
    logic aw_ready_c;
    logic aw_hs;
    logic rd_load;
    logic ar_gate;
    logic rd_ar_ready;
    logic rd_idle;
    logic r_valid;
    logic r_last;
    id_t  r_id;

    // Payload fields this responder never looks at
    logic unused;
    assign unused = ^{axi.req.aw.addr, axi.req.aw.size, axi.req.aw.burst,
                      axi.req.aw.atop[AtopRRespBit-1:0],
                      axi.req.w.data, axi.req.w.strb,
                      axi.req.ar.addr, axi.req.ar.size, axi.req.ar.burst};

    // live_q holds readies low for the first cycle after reset
    assign aw_is_atop = axi.req.aw.atop[AtopRRespBit];
    assign aw_ready_c = live_q && en_i && (w_state_q == W_IDLE) &&
                        (!aw_is_atop || rd_idle);
    assign aw_hs      = axi.req.aw_valid && aw_ready_c;
    assign rd_load    = aw_hs && aw_is_atop;
    // An atomic AW on offer wins over a concurrent AR
    assign ar_gate    = live_q && en_i &&
                        !(axi.req.aw_valid && aw_is_atop && (w_state_q == W_IDLE));

    // Write FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            b_id_q    <= '0;
            live_q    <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        b_id_q    <= axi.req.aw.id;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi.req.w_valid && axi.req.w.last) begin
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi.req.b_ready) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    axi_err_resp_rd i_rd (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ar_en_i    (ar_gate),
        .ar_valid_i (axi.req.ar_valid),
        .ar_id_i    (axi.req.ar.id),
        .ar_len_i   (axi.req.ar.len),
        .load_i     (rd_load),
        .load_id_i  (axi.req.aw.id),
        .load_len_i (axi.req.aw.len),
        .r_ready_i  (axi.req.r_ready),
        .ar_ready_o (rd_ar_ready),
        .r_valid_o  (r_valid),
        .r_id_o     (r_id),
        .r_last_o   (r_last),
        .idle_o     (rd_idle)
    );

    // Response bundle: decodes of registered state plus constants
    always_comb begin
        axi.resp          = '0;
        axi.resp.aw_ready = aw_ready_c;
        axi.resp.w_ready  = (w_state_q == W_DATA);
        axi.resp.b_valid  = (w_state_q == W_RESP);
        axi.resp.b.id     = b_id_q;
        axi.resp.b.resp   = RespCode;
        axi.resp.ar_ready = rd_ar_ready;
        axi.resp.r_valid  = r_valid;
        axi.resp.r.id     = r_id;
        axi.resp.r.data   = AxiDataWidth'(RData);
        axi.resp.r.resp   = RespCode;
        axi.resp.r.last   = r_last;
    end

    assign busy_o = (w_state_q != W_IDLE) || !rd_idle;

`ifdef AXI_ERR_RESP_CNT_EN
    cnt_t wr_cnt_q;
    cnt_t rd_cnt_q;
    logic b_hs;
    logic r_done_hs;

    assign b_hs      = (w_state_q == W_RESP) && axi.req.b_ready;
    assign r_done_hs = r_valid && r_last && axi.req.r_ready;

    // Saturating completion counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (b_hs && (wr_cnt_q != CNT_MAX)) begin
                wr_cnt_q <= wr_cnt_q + CntWidth'(1);
            end
            if (r_done_hs && (rd_cnt_q != CNT_MAX)) begin
                rd_cnt_q <= rd_cnt_q + CntWidth'(1);
            end
        end
    end

    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;
`else
    assign wr_cnt_o = '0;
    assign rd_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_err_responder.sv
// Directed bench for axi_err_responder: inputs change on the falling edge,
// outputs are sampled 1 time unit later, handshakes happen on the rising edge.
module tb_axi_err_responder;
    import axi_err_responder_pkg::*;

`ifdef AXI_ERR_RESP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [AxiDataWidth-1:0] EXP_DATA = 64'hBADC_AB1E_DEAD_BEEF;
    localparam logic [1:0]              EXP_RESP = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        busy;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    int vectors     = 0;
    int miscompares = 0;

    axi_err_responder_if bus ();

    axi_err_responder dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .axi      (bus),
        .busy_o   (busy),
        .wr_cnt_o (wr_cnt),
        .rd_cnt_o (rd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        bus.req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (bus.resp.aw_ready !== 1'b0) begin miscompares++; $display("FAIL reset_aw_ready: got %b want 0", bus.resp.aw_ready); end
        vectors++; if (bus.resp.ar_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ar_ready: got %b want 0", bus.resp.ar_ready); end
        vectors++; if (bus.resp.w_ready !== 1'b0) begin miscompares++; $display("FAIL reset_w_ready: got %b want 0", bus.resp.w_ready); end
        vectors++; if (bus.resp.b_valid !== 1'b0) begin miscompares++; $display("FAIL reset_b_valid: got %b want 0", bus.resp.b_valid); end
        vectors++; if (bus.resp.r_valid !== 1'b0) begin miscompares++; $display("FAIL reset_r_valid: got %b want 0", bus.resp.r_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (wr_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); end
        vectors++; if (rd_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_rd_cnt: got %0d want 0", rd_cnt); end
        @(negedge clk);
        #1;
        vectors++; if (bus.resp.aw_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_aw_ready: got %b want 1", bus.resp.aw_ready); end
        vectors++; if (bus.resp.ar_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ar_ready: got %b want 1", bus.resp.ar_ready); end
    endtask

    task automatic test_enable_gate();
        @(negedge clk);
        en = 1'b0;
        bus.req.aw = '0; bus.req.aw.id = 6'd1; bus.req.aw_valid = 1'b1;
        bus.req.ar = '0; bus.req.ar.id = 6'd1; bus.req.ar_valid = 1'b1;
        #1;
        vectors++; if (bus.resp.aw_ready !== 1'b0) begin miscompares++; $display("FAIL en_off_aw_ready: got %b want 0", bus.resp.aw_ready); end
        vectors++; if (bus.resp.ar_ready !== 1'b0) begin miscompares++; $display("FAIL en_off_ar_ready: got %b want 0", bus.resp.ar_ready); end
        @(negedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL en_off_busy: got %b want 0", busy); end
        bus.req.aw_valid = 1'b0;
        bus.req.ar_valid = 1'b0;
        en = 1'b1;
    endtask

    // Plain write of 'beats' W beats; W offered from the cycle after AW
    task automatic write_txn(input logic [5:0] id, input int beats);
        @(negedge clk);
        bus.req.aw = '0; bus.req.aw.id = id; bus.req.aw.len = 8'(beats - 1); bus.req.aw_valid = 1'b1;
        #1;
        vectors++; if (bus.resp.aw_ready !== 1'b1) begin miscompares++; $display("FAIL wr_aw_ready id=%0d: got %b want 1", id, bus.resp.aw_ready); end
        for (int i = 0; i < beats; i++) begin
            @(negedge clk);
            bus.req.aw_valid = 1'b0;
            bus.req.w.data = 64'(i); bus.req.w.last = (i == beats - 1); bus.req.w_valid = 1'b1;
            #1;
            vectors++; if (bus.resp.w_ready !== 1'b1) begin miscompares++; $display("FAIL wr_w_ready id=%0d beat=%0d: got %b want 1", id, i, bus.resp.w_ready); end
            vectors++; if (bus.resp.b_valid !== 1'b0) begin miscompares++; $display("FAIL wr_b_early id=%0d beat=%0d: got %b want 0", id, i, bus.resp.b_valid); end
        end
        @(negedge clk);
        bus.req.w_valid = 1'b0; bus.req.w.last = 1'b0;
        #1;
        vectors++; if (bus.resp.b_valid !== 1'b1) begin miscompares++; $display("FAIL wr_b_valid id=%0d: got %b want 1", id, bus.resp.b_valid); end
        vectors++; if (bus.resp.b.id !== id) begin miscompares++; $display("FAIL wr_b_id: got %0d want %0d", bus.resp.b.id, id); end
        vectors++; if (bus.resp.b.resp !== EXP_RESP) begin miscompares++; $display("FAIL wr_b_resp: got %b want %b", bus.resp.b.resp, EXP_RESP); end
        vectors++; if (bus.resp.b.user !== '0) begin miscompares++; $display("FAIL wr_b_user: got %b want 0", bus.resp.b.user); end
        vectors++; if (bus.resp.w_ready !== 1'b0) begin miscompares++; $display("FAIL wr_w_ready_resp: got %b want 0", bus.resp.w_ready); end
        bus.req.b_ready = 1'b1;
        @(negedge clk);
        bus.req.b_ready = 1'b0;
        #1;
        vectors++; if (bus.resp.b_valid !== 1'b0) begin miscompares++; $display("FAIL wr_b_drop id=%0d: got %b want 0", id, bus.resp.b_valid); end
    endtask

    // One AR burst; r_ready random or held high; en_i dropped at beat drop_beat (-1 = never)
    task automatic read_burst(input logic [5:0] id, input logic [7:0] len, input bit rnd, input int drop_beat);
        int   beats;
        int   cyc;
        bit   done;
        logic exp_last;
        @(negedge clk);
        bus.req.ar = '0; bus.req.ar.id = id; bus.req.ar.len = len; bus.req.ar_valid = 1'b1;
        #1;
        vectors++; if (bus.resp.ar_ready !== 1'b1) begin miscompares++; $display("FAIL rd_ar_ready id=%0d: got %b want 1", id, bus.resp.ar_ready); end
        @(negedge clk);
        bus.req.ar_valid = 1'b0;
        beats = 0;
        cyc   = 1;
        done  = 1'b0;
        while (!done && cyc < 3000) begin
            if (drop_beat >= 0 && beats == drop_beat) en = 1'b0;
            bus.req.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_last = (beats == int'(len));
            #1;
            vectors++; if (bus.resp.r_valid !== 1'b1) begin miscompares++; $display("FAIL rd_valid id=%0d beat=%0d: got %b want 1", id, beats, bus.resp.r_valid); end
            vectors++; if (bus.resp.r.last !== exp_last) begin miscompares++; $display("FAIL rd_last id=%0d beat=%0d: got %b want %b", id, beats, bus.resp.r.last, exp_last); end
            vectors++; if (bus.resp.r.id !== id) begin miscompares++; $display("FAIL rd_id beat=%0d: got %0d want %0d", beats, bus.resp.r.id, id); end
            vectors++; if (bus.resp.r.data !== EXP_DATA) begin miscompares++; $display("FAIL rd_data beat=%0d: got %h want %h", beats, bus.resp.r.data, EXP_DATA); end
            vectors++; if (bus.resp.r.resp !== EXP_RESP) begin miscompares++; $display("FAIL rd_resp beat=%0d: got %b want %b", beats, bus.resp.r.resp, EXP_RESP); end
            vectors++; if (bus.resp.ar_ready !== 1'b0) begin miscompares++; $display("FAIL rd_ar_busy beat=%0d: got %b want 0", beats, bus.resp.ar_ready); end
            if (bus.req.r_ready) begin
                if (exp_last) done = 1'b1;
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.req.r_ready = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL rd_timeout id=%0d: got %0d beats want %0d", id, beats, int'(len) + 1);
        end
        #1;
        vectors++; if (bus.resp.r_valid !== 1'b0) begin miscompares++; $display("FAIL rd_end_valid id=%0d: got %b want 0", id, bus.resp.r_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_end_busy id=%0d: got %b want 0", id, busy); end
    endtask

    task automatic test_write_single();
        write_txn(6'd5, 1);
        write_txn(6'd9, 4);
    endtask

    task automatic test_read_basic();
        read_burst(6'd3, 8'd3, 1'b0, -1);
        read_burst(6'd0, 8'd0, 1'b0, -1);
    endtask

    task automatic test_read_long();
        read_burst(6'd12, 8'd255, 1'b1, -1);
    endtask

    task automatic test_atomic();
        @(negedge clk);
        bus.req.aw = '0; bus.req.aw.id = 6'd7; bus.req.aw.len = 8'd1; bus.req.aw.atop = 6'b100000; bus.req.aw_valid = 1'b1;
        bus.req.ar = '0; bus.req.ar.id = 6'd2; bus.req.ar.len = 8'd0; bus.req.ar_valid = 1'b1;
        #1;
        vectors++; if (bus.resp.aw_ready !== 1'b1) begin miscompares++; $display("FAIL atop_aw_ready: got %b want 1", bus.resp.aw_ready); end
        vectors++; if (bus.resp.ar_ready !== 1'b0) begin miscompares++; $display("FAIL atop_ar_blocked: got %b want 0", bus.resp.ar_ready); end
        @(negedge clk);
        bus.req.aw_valid = 1'b0;
        bus.req.w.last = 1'b0; bus.req.w_valid = 1'b1;
        bus.req.r_ready = 1'b1;
        #1;
        vectors++; if (bus.resp.r_valid !== 1'b1) begin miscompares++; $display("FAIL atop_r0_valid: got %b want 1", bus.resp.r_valid); end
        vectors++; if (bus.resp.r.id !== 6'd7) begin miscompares++; $display("FAIL atop_r0_id: got %0d want 7", bus.resp.r.id); end
        vectors++; if (bus.resp.r.last !== 1'b0) begin miscompares++; $display("FAIL atop_r0_last: got %b want 0", bus.resp.r.last); end
        vectors++; if (bus.resp.ar_ready !== 1'b0) begin miscompares++; $display("FAIL atop_ar_busy: got %b want 0", bus.resp.ar_ready); end
        vectors++; if (bus.resp.w_ready !== 1'b1) begin miscompares++; $display("FAIL atop_w_ready: got %b want 1", bus.resp.w_ready); end
        @(negedge clk);
        bus.req.w.last = 1'b1;
        #1;
        vectors++; if (bus.resp.r_valid !== 1'b1) begin miscompares++; $display("FAIL atop_r1_valid: got %b want 1", bus.resp.r_valid); end
        vectors++; if (bus.resp.r.last !== 1'b1) begin miscompares++; $display("FAIL atop_r1_last: got %b want 1", bus.resp.r.last); end
        vectors++; if (bus.resp.r.id !== 6'd7) begin miscompares++; $display("FAIL atop_r1_id: got %0d want 7", bus.resp.r.id); end
        @(negedge clk);
        bus.req.w_valid = 1'b0; bus.req.w.last = 1'b0;
        bus.req.r_ready = 1'b0;
        #1;
        vectors++; if (bus.resp.b_valid !== 1'b1) begin miscompares++; $display("FAIL atop_b_valid: got %b want 1", bus.resp.b_valid); end
        vectors++; if (bus.resp.b.id !== 6'd7) begin miscompares++; $display("FAIL atop_b_id: got %0d want 7", bus.resp.b.id); end
        vectors++; if (bus.resp.r_valid !== 1'b0) begin miscompares++; $display("FAIL atop_r_done: got %b want 0", bus.resp.r_valid); end
        vectors++; if (bus.resp.ar_ready !== 1'b1) begin miscompares++; $display("FAIL atop_ar_after: got %b want 1", bus.resp.ar_ready); end
        bus.req.b_ready = 1'b1;
        @(negedge clk);
        bus.req.b_ready = 1'b0;
        bus.req.ar_valid = 1'b0;
        bus.req.r_ready = 1'b1;
        #1;
        vectors++; if (bus.resp.b_valid !== 1'b0) begin miscompares++; $display("FAIL atop_b_drop: got %b want 0", bus.resp.b_valid); end
        vectors++; if (bus.resp.r_valid !== 1'b1) begin miscompares++; $display("FAIL atop_ar2_valid: got %b want 1", bus.resp.r_valid); end
        vectors++; if (bus.resp.r.id !== 6'd2) begin miscompares++; $display("FAIL atop_ar2_id: got %0d want 2", bus.resp.r.id); end
        vectors++; if (bus.resp.r.last !== 1'b1) begin miscompares++; $display("FAIL atop_ar2_last: got %b want 1", bus.resp.r.last); end
        @(negedge clk);
        bus.req.r_ready = 1'b0;
        #1;
        vectors++; if (bus.resp.r_valid !== 1'b0) begin miscompares++; $display("FAIL atop_end_valid: got %b want 0", bus.resp.r_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL atop_end_busy: got %b want 0", busy); end
    endtask

    // Concurrent AW (non-read atomic, atop[5]=0) and AR both accepted
    task automatic test_back_to_back();
        @(negedge clk);
        bus.req.aw = '0; bus.req.aw.id = 6'd1; bus.req.aw.atop = 6'b010001; bus.req.aw_valid = 1'b1;
        bus.req.ar = '0; bus.req.ar.id = 6'd4; bus.req.ar_valid = 1'b1;
        #1;
        vectors++; if (bus.resp.aw_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_aw_ready: got %b want 1", bus.resp.aw_ready); end
        vectors++; if (bus.resp.ar_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ar_ready: got %b want 1", bus.resp.ar_ready); end
        @(negedge clk);
        bus.req.aw_valid = 1'b0; bus.req.ar_valid = 1'b0;
        bus.req.w.last = 1'b1; bus.req.w_valid = 1'b1;
        bus.req.r_ready = 1'b1;
        #1;
        vectors++; if (bus.resp.r_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_r_valid: got %b want 1", bus.resp.r_valid); end
        vectors++; if (bus.resp.r.id !== 6'd4) begin miscompares++; $display("FAIL b2b_r_id: got %0d want 4", bus.resp.r.id); end
        vectors++; if (bus.resp.r.last !== 1'b1) begin miscompares++; $display("FAIL b2b_r_last: got %b want 1", bus.resp.r.last); end
        vectors++; if (bus.resp.w_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_w_ready: got %b want 1", bus.resp.w_ready); end
        @(negedge clk);
        bus.req.w_valid = 1'b0; bus.req.w.last = 1'b0;
        bus.req.r_ready = 1'b0;
        #1;
        vectors++; if (bus.resp.b_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_b_valid: got %b want 1", bus.resp.b_valid); end
        vectors++; if (bus.resp.b.id !== 6'd1) begin miscompares++; $display("FAIL b2b_b_id: got %0d want 1", bus.resp.b.id); end
        vectors++; if (bus.resp.r_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_r_done: got %b want 0", bus.resp.r_valid); end
        bus.req.b_ready = 1'b1;
        @(negedge clk);
        bus.req.b_ready = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy: got %b want 0", busy); end
    endtask

    task automatic test_en_drop();
        read_burst(6'd21, 8'd7, 1'b0, 2);
        #1;
        vectors++; if (bus.resp.ar_ready !== 1'b0) begin miscompares++; $display("FAIL en_drop_ar_ready: got %b want 0", bus.resp.ar_ready); end
        vectors++; if (bus.resp.aw_ready !== 1'b0) begin miscompares++; $display("FAIL en_drop_aw_ready: got %b want 0", bus.resp.aw_ready); end
        en = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        bus.req.aw = '0; bus.req.aw.id = 6'd2; bus.req.aw.len = 8'd3; bus.req.aw_valid = 1'b1;
        bus.req.ar = '0; bus.req.ar.id = 6'd9; bus.req.ar.len = 8'd7; bus.req.ar_valid = 1'b1;
        @(negedge clk);
        bus.req.aw_valid = 1'b0; bus.req.ar_valid = 1'b0;
        bus.req.r_ready = 1'b1;
        #1;
        vectors++; if (bus.resp.r_valid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre_valid: got %b want 1", bus.resp.r_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy); end
        @(negedge clk);
        bus.req.r_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if (bus.resp.r_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_r_valid: got %b want 0", bus.resp.r_valid); end
        vectors++; if (bus.resp.w_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_w_ready: got %b want 0", bus.resp.w_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        vectors++; if (wr_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_mid_wr_cnt: got %0d want 0", wr_cnt); end
        vectors++; if (rd_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_mid_rd_cnt: got %0d want 0", rd_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_counters();
        logic [15:0] exp_wr;
        logic [15:0] exp_rd;
        write_txn(6'd1, 1);
        write_txn(6'd2, 2);
        write_txn(6'd3, 1);
        read_burst(6'd4, 8'd1, 1'b0, -1);
        exp_wr = CNT_EN ? 16'd3 : 16'd0;
        exp_rd = CNT_EN ? 16'd1 : 16'd0;
        #1;
        vectors++; if (wr_cnt !== exp_wr) begin miscompares++; $display("FAIL cnt_wr: got %0d want %0d", wr_cnt, exp_wr); end
        vectors++; if (rd_cnt !== exp_rd) begin miscompares++; $display("FAIL cnt_rd: got %0d want %0d", rd_cnt, exp_rd); end
    endtask

    initial begin
        bus.req = '0;
        test_reset();
        test_enable_gate();
        test_write_single();
        test_read_basic();
        test_read_long();
        test_atomic();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_burst();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
